// File: rtl/bus_select_reg_if.sv
// ============================================================================
// Module      : bus_select_reg_if
// Description : Bus-source bundle for bus_select_reg. Carries the flattened
//               source words, the per-source out strobes, the stall input
//               and the registered bus results.
//   master : drives src_data, src_out, hold; observes the bus outputs
//   slave  : the selector itself
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_select_reg_if #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 24,
    parameter int SELW  = $clog2(N_SRC)
);
    logic [N_SRC*WIDTH-1:0] src_data;
    logic [N_SRC-1:0]       src_out;
    logic                   hold;
    logic [WIDTH-1:0]       bus_out;
    logic                   bus_valid;
    logic [SELW-1:0]        bus_sel;
    logic                   conflict;
    logic [15:0]            conflict_count;

    modport master (
        output src_data, src_out, hold,
        input  bus_out, bus_valid, bus_sel, conflict, conflict_count
    );

    modport slave (
        input  src_data, src_out, hold,
        output bus_out, bus_valid, bus_sel, conflict, conflict_count
    );
endinterface

`default_nettype wire

// File: rtl/bus_select_reg.sv
// ============================================================================
// Module      : bus_select_reg
// Description : Registered N-to-1 bus selector driven by one-per-source out
//               strobes. Simultaneous strobes are resolved by fixed priority
//               (lowest index) or round-robin; the winner is registered onto
//               the bus. Idle cycles either hold or zero the bus, and strobe
//               conflicts are flagged and counted (saturating).
// Ports       :
//   clock : rising-edge clock
//   clear : synchronous active-high reset, dominates everything
//   bif   : slave side of bus_select_reg_if
//           (src_data, src_out, hold in; bus_out, bus_valid, bus_sel,
//            conflict, conflict_count out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_select_reg #(
    parameter int WIDTH     = 32,
    parameter int N_SRC     = 24,
    parameter int PRIO_MODE = 0,
    parameter int HOLD_EN   = 1
) (
    input  wire logic        clock,
    input  wire logic        clear,
    bus_select_reg_if.slave  bif
);
    localparam int SELW = $clog2(N_SRC);
    localparam logic [N_SRC-1:0] c_one = {{(N_SRC-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bus_out;
    logic             r_bus_valid;
    logic [SELW-1:0]  r_bus_sel;
    logic             r_conflict;
    logic [15:0]      r_conflict_count;
    logic [SELW-1:0]  r_rr_ptr;

    logic             w_lo_found;
    logic [SELW-1:0]  w_lo_idx;
    logic             w_hi_found;
    logic [SELW-1:0]  w_hi_idx;
    logic [SELW-1:0]  w_grant_idx;
    logic             w_any;
    logic             w_multi;
    logic [WIDTH-1:0] w_grant_word;
    logic [SELW-1:0]  w_rr_next;

    // Downward scan so the last hit is the lowest index. w_lo_* is the lowest
    // set strobe overall; w_hi_* is the lowest set strobe at or above the
    // round-robin pointer. If nothing lies at/above the pointer, the search
    // wraps, which is exactly the lowest set strobe overall.
    always_comb begin
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (bif.src_out[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = SELW'(i);
                if (i >= int'(r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SELW'(i);
                end
            end
        end
    end

    assign w_grant_idx  = ((PRIO_MODE != 0) && w_hi_found) ? w_hi_idx : w_lo_idx;
    assign w_any        = w_lo_found;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi      = |(bif.src_out & (bif.src_out - c_one));
    assign w_grant_word = bif.src_data[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_rr_next    = (w_grant_idx == SELW'(N_SRC - 1)) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_bus_out        <= '0;
            r_bus_valid      <= 1'b0;
            r_bus_sel        <= '0;
            r_conflict       <= 1'b0;
            r_conflict_count <= '0;
            r_rr_ptr         <= '0;
        end else if (!bif.hold) begin
            r_conflict <= w_multi;
            if (w_multi && (r_conflict_count != 16'hFFFF)) begin
                r_conflict_count <= r_conflict_count + 16'd1;
            end
            if (w_any) begin
                r_bus_out   <= w_grant_word;
                r_bus_sel   <= w_grant_idx;
                r_bus_valid <= 1'b1;
                if (PRIO_MODE != 0) begin
                    r_rr_ptr <= w_rr_next;
                end
            end else begin
                r_bus_valid <= 1'b0;
                if (HOLD_EN == 0) begin
                    r_bus_out <= '0;
                end
            end
        end
    end

    assign bif.bus_out        = r_bus_out;
    assign bif.bus_valid      = r_bus_valid;
    assign bif.bus_sel        = r_bus_sel;
    assign bif.conflict       = r_conflict;
    assign bif.conflict_count = r_conflict_count;

endmodule

`default_nettype wire

// File: tb/tb_bus_select_reg.sv
// ============================================================================
// Module      : tb_bus_select_reg
// Description : Directed bench for bus_select_reg. Two instances share the
//               same stimulus: u_fp (fixed priority, bus holds when idle) and
//               u_rr (round-robin, bus zeroes when idle).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_select_reg;
    localparam int WIDTH = 32;
    localparam int N_SRC = 24;
    localparam int SELW  = 5;

    logic                   clock = 1'b0;
    logic                   clear = 1'b1;
    logic [N_SRC*WIDTH-1:0] src_data = '0;
    logic [N_SRC-1:0]       src_out = '0;
    logic                   hold = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    bus_select_reg_if #(.WIDTH(WIDTH), .N_SRC(N_SRC)) if_fp ();
    bus_select_reg_if #(.WIDTH(WIDTH), .N_SRC(N_SRC)) if_rr ();

    assign if_fp.src_data = src_data;
    assign if_fp.src_out  = src_out;
    assign if_fp.hold     = hold;
    assign if_rr.src_data = src_data;
    assign if_rr.src_out  = src_out;
    assign if_rr.hold     = hold;

    bus_select_reg #(.WIDTH(WIDTH), .N_SRC(N_SRC), .PRIO_MODE(0), .HOLD_EN(1)) u_fp (
        .clock (clock),
        .clear (clear),
        .bif   (if_fp)
    );

    bus_select_reg #(.WIDTH(WIDTH), .N_SRC(N_SRC), .PRIO_MODE(1), .HOLD_EN(0)) u_rr (
        .clock (clock),
        .clear (clear),
        .bif   (if_rr)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [WIDTH-1:0] val);
        src_data[idx*WIDTH +: WIDTH] = val;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear   = 1'b1;
        src_out = N_SRC'($urandom);
        for (int i = 0; i < N_SRC; i++) set_word(i, $urandom);
        step();
        src_out = N_SRC'($urandom) | 24'h000003;
        step();
        total++; if (if_fp.bus_out !== 32'h0) begin bad++; $display("FAIL reset_fp_out got=%h exp=0", if_fp.bus_out); end
        total++; if (if_fp.bus_valid !== 1'b0) begin bad++; $display("FAIL reset_fp_valid got=%b exp=0", if_fp.bus_valid); end
        total++; if (if_fp.bus_sel !== 5'd0) begin bad++; $display("FAIL reset_fp_sel got=%0d exp=0", if_fp.bus_sel); end
        total++; if (if_fp.conflict !== 1'b0) begin bad++; $display("FAIL reset_fp_conflict got=%b exp=0", if_fp.conflict); end
        total++; if (if_fp.conflict_count !== 16'h0) begin bad++; $display("FAIL reset_fp_count got=%h exp=0", if_fp.conflict_count); end
        total++; if (if_rr.bus_out !== 32'h0) begin bad++; $display("FAIL reset_rr_out got=%h exp=0", if_rr.bus_out); end
        total++; if (if_rr.bus_valid !== 1'b0) begin bad++; $display("FAIL reset_rr_valid got=%b exp=0", if_rr.bus_valid); end
        clear   = 1'b0;
        src_out = '0;
        step();
        step();
        total++; if (if_fp.bus_out !== 32'h0) begin bad++; $display("FAIL idle_fp_out got=%h exp=0", if_fp.bus_out); end
        total++; if (if_fp.bus_valid !== 1'b0) begin bad++; $display("FAIL idle_fp_valid got=%b exp=0", if_fp.bus_valid); end
    endtask

    task automatic test_single();
        set_word(21, 32'hDEADBEEF);
        src_out = 24'h1 << 21;
        step();
        total++; if (if_fp.bus_out !== 32'hDEADBEEF) begin bad++; $display("FAIL single_fp_out got=%h exp=deadbeef", if_fp.bus_out); end
        total++; if (if_fp.bus_sel !== 5'd21) begin bad++; $display("FAIL single_fp_sel got=%0d exp=21", if_fp.bus_sel); end
        total++; if (if_fp.bus_valid !== 1'b1) begin bad++; $display("FAIL single_fp_valid got=%b exp=1", if_fp.bus_valid); end
        total++; if (if_fp.conflict !== 1'b0) begin bad++; $display("FAIL single_fp_conflict got=%b exp=0", if_fp.conflict); end
        total++; if (if_rr.bus_sel !== 5'd21) begin bad++; $display("FAIL single_rr_sel got=%0d exp=21", if_rr.bus_sel); end
        src_out = '0;
        step();
        total++; if (if_fp.bus_out !== 32'hDEADBEEF) begin bad++; $display("FAIL idlehold_fp_out got=%h exp=deadbeef", if_fp.bus_out); end
        total++; if (if_fp.bus_valid !== 1'b0) begin bad++; $display("FAIL idlehold_fp_valid got=%b exp=0", if_fp.bus_valid); end
        total++; if (if_fp.bus_sel !== 5'd21) begin bad++; $display("FAIL idlehold_fp_sel got=%0d exp=21", if_fp.bus_sel); end
        total++; if (if_rr.bus_out !== 32'h0) begin bad++; $display("FAIL idlezero_rr_out got=%h exp=0", if_rr.bus_out); end
        total++; if (if_rr.bus_valid !== 1'b0) begin bad++; $display("FAIL idlezero_rr_valid got=%b exp=0", if_rr.bus_valid); end
    endtask

    task automatic test_fixed_conflict();
        do_clear();
        set_word(3, 32'h3);
        set_word(19, 32'h13);
        src_out = (24'h1 << 3) | (24'h1 << 19);
        step();
        total++; if (if_fp.bus_sel !== 5'd3) begin bad++; $display("FAIL fixprio_sel got=%0d exp=3", if_fp.bus_sel); end
        total++; if (if_fp.bus_out !== 32'h3) begin bad++; $display("FAIL fixprio_out got=%h exp=3", if_fp.bus_out); end
        total++; if (if_fp.conflict !== 1'b1) begin bad++; $display("FAIL fixprio_conflict got=%b exp=1", if_fp.conflict); end
        total++; if (if_fp.conflict_count !== 16'd1) begin bad++; $display("FAIL fixprio_count got=%0d exp=1", if_fp.conflict_count); end
        src_out = 24'h1 << 19;
        step();
        total++; if (if_fp.conflict !== 1'b0) begin bad++; $display("FAIL fixprio_pulse got=%b exp=0", if_fp.conflict); end
        total++; if (if_fp.bus_out !== 32'h13) begin bad++; $display("FAIL fixprio_out19 got=%h exp=13", if_fp.bus_out); end
        total++; if (if_fp.conflict_count !== 16'd1) begin bad++; $display("FAIL fixprio_count2 got=%0d exp=1", if_fp.conflict_count); end
    endtask

    task automatic test_round_robin();
        logic [SELW-1:0] exp_sel [4];
        exp_sel[0] = 5'd0; exp_sel[1] = 5'd5; exp_sel[2] = 5'd23; exp_sel[3] = 5'd0;
        do_clear();
        for (int i = 0; i < N_SRC; i++) set_word(i, 32'h100 + i);
        src_out = (24'h1 << 0) | (24'h1 << 5) | (24'h1 << 23);
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (if_rr.bus_sel !== exp_sel[k]) begin bad++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", k, if_rr.bus_sel, exp_sel[k]); end
            total++; if (if_rr.bus_out !== (32'h100 + 32'(exp_sel[k]))) begin bad++; $display("FAIL rr_out[%0d] got=%h exp=%h", k, if_rr.bus_out, 32'h100 + 32'(exp_sel[k])); end
            total++; if (if_fp.bus_sel !== 5'd0) begin bad++; $display("FAIL rr_fp_sel[%0d] got=%0d exp=0", k, if_fp.bus_sel); end
        end
        total++; if (if_rr.conflict_count !== 16'd4) begin bad++; $display("FAIL rr_count got=%0d exp=4", if_rr.conflict_count); end
        src_out = '0;
        step();
        total++; if (if_rr.bus_out !== 32'h0) begin bad++; $display("FAIL rr_idle_out got=%h exp=0", if_rr.bus_out); end
        total++; if (if_rr.bus_sel !== 5'd0) begin bad++; $display("FAIL rr_idle_sel got=%0d exp=0", if_rr.bus_sel); end
    endtask

    task automatic test_back_to_back();
        src_out = 24'h1 << 7;
        for (int k = 0; k < 3; k++) begin
            set_word(7, 32'h70 + k);
            step();
            total++; if (if_fp.bus_out !== (32'h70 + k)) begin bad++; $display("FAIL b2b_fp_out[%0d] got=%h exp=%h", k, if_fp.bus_out, 32'h70 + k); end
            total++; if (if_rr.bus_valid !== 1'b1) begin bad++; $display("FAIL b2b_rr_valid[%0d] got=%b exp=1", k, if_rr.bus_valid); end
        end
    endtask

    task automatic test_hold();
        do_clear();
        set_word(2, 32'hAAAA0002);
        src_out = 24'h1 << 2;
        step();
        hold = 1'b1;
        src_out = 24'h000203;
        set_word(2, 32'h55555555);
        step();
        src_out = 24'hFFFFFF;
        step();
        src_out = 24'h1 << 9;
        step();
        total++; if (if_fp.bus_out !== 32'hAAAA0002) begin bad++; $display("FAIL hold_fp_out got=%h exp=aaaa0002", if_fp.bus_out); end
        total++; if (if_fp.bus_sel !== 5'd2) begin bad++; $display("FAIL hold_fp_sel got=%0d exp=2", if_fp.bus_sel); end
        total++; if (if_fp.bus_valid !== 1'b1) begin bad++; $display("FAIL hold_fp_valid got=%b exp=1", if_fp.bus_valid); end
        total++; if (if_fp.conflict !== 1'b0) begin bad++; $display("FAIL hold_fp_conflict got=%b exp=0", if_fp.conflict); end
        total++; if (if_fp.conflict_count !== 16'd0) begin bad++; $display("FAIL hold_fp_count got=%0d exp=0", if_fp.conflict_count); end
        total++; if (if_rr.bus_out !== 32'hAAAA0002) begin bad++; $display("FAIL hold_rr_out got=%h exp=aaaa0002", if_rr.bus_out); end
        // Release: pointer must still be 3, so rr skips source 1 and takes 4.
        hold = 1'b0;
        set_word(1, 32'h11);
        set_word(4, 32'h44);
        src_out = (24'h1 << 1) | (24'h1 << 4);
        step();
        total++; if (if_fp.bus_sel !== 5'd1) begin bad++; $display("FAIL release_fp_sel got=%0d exp=1", if_fp.bus_sel); end
        total++; if (if_rr.bus_sel !== 5'd4) begin bad++; $display("FAIL release_rr_sel got=%0d exp=4", if_rr.bus_sel); end
        total++; if (if_rr.bus_out !== 32'h44) begin bad++; $display("FAIL release_rr_out got=%h exp=44", if_rr.bus_out); end
        total++; if (if_fp.conflict_count !== 16'd1) begin bad++; $display("FAIL release_fp_count got=%0d exp=1", if_fp.conflict_count); end
    endtask

    task automatic test_saturation();
        do_clear();
        src_out = 24'h000003;
        for (int k = 0; k < 65534; k++) @(posedge clock);
        #1;
        total++; if (if_fp.conflict_count !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", if_fp.conflict_count); end
        step();
        total++; if (if_fp.conflict_count !== 16'hFFFF) begin bad++; $display("FAIL sat_1 got=%h exp=ffff", if_fp.conflict_count); end
        step();
        step();
        total++; if (if_fp.conflict_count !== 16'hFFFF) begin bad++; $display("FAIL sat_3_fp got=%h exp=ffff", if_fp.conflict_count); end
        total++; if (if_rr.conflict_count !== 16'hFFFF) begin bad++; $display("FAIL sat_3_rr got=%h exp=ffff", if_rr.conflict_count); end
        total++; if (if_fp.conflict !== 1'b1) begin bad++; $display("FAIL sat_conflict got=%b exp=1", if_fp.conflict); end
        hold  = 1'b1;
        clear = 1'b1;
        step();
        total++; if (if_fp.conflict_count !== 16'h0) begin bad++; $display("FAIL clrhold_count got=%h exp=0", if_fp.conflict_count); end
        total++; if (if_fp.bus_valid !== 1'b0) begin bad++; $display("FAIL clrhold_valid got=%b exp=0", if_fp.bus_valid); end
        total++; if (if_fp.conflict !== 1'b0) begin bad++; $display("FAIL clrhold_conflict got=%b exp=0", if_fp.conflict); end
        total++; if (if_rr.bus_sel !== 5'd0) begin bad++; $display("FAIL clrhold_rr_sel got=%0d exp=0", if_rr.bus_sel); end
        total++; if (if_fp.bus_out !== 32'h0) begin bad++; $display("FAIL clrhold_out got=%h exp=0", if_fp.bus_out); end
        clear = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fixed_conflict();
        test_round_robin();
        test_back_to_back();
        test_hold();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
